// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server
//   Serves HPS "upload" byte reads (core -> HPS file save) for one ioctl_index.
//   Each HPS read strobe inside a session is turned into a single read on a
//   shared memory port, with the HPS stalled via ioctl_wait until the byte
//   comes back. Addresses beyond the backing memory return 8'hFF immediately.
//   The core CPU is paused for the duration of the session.
//
// Ports
//   clk_sys       : single rising-edge clock
//   reset_n       : asynchronous active-low reset (release synchronized inside)
//   ioctl_upload  : HPS upload session active (level)
//   ioctl_index   : file index of the current session
//   ioctl_rd      : one-cycle byte read strobe from HPS
//   ioctl_addr    : byte address qualified by ioctl_rd
//   ioctl_din     : byte returned to HPS
//   ioctl_wait    : stall to HPS, high while a read is outstanding
//   mem_addr      : read address to the shared memory port
//   mem_rd        : read request to the shared memory port
//   mem_busy      : core owns the memory port this cycle
//   mem_dout      : memory data, valid the cycle after an accepted mem_rd
//   core_pause    : freeze request to the core CPU
//   upload_done   : one-cycle pulse after the session ends
//   byte_count    : reads completed in the current or last session
module ioctl_upload_server #(
  parameter logic [7:0] UPLOAD_INDEX = 8'd2,
  parameter int         ADDR_WIDTH   = 12
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_upload,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_rd,
  input  logic [24:0]           ioctl_addr,
  output logic [7:0]            ioctl_din,
  output logic                  ioctl_wait,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_busy,
  input  logic [7:0]            mem_dout,
  output logic                  core_pause,
  output logic                  upload_done,
  output logic [15:0]           byte_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic rst_sync_p0, rst_sync_p1;
  logic rst_n_int;
  logic session, session_q, session_fall, session_rise;
  logic in_range, rd_take, read_done;
  logic [15:0] count_base;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reset: assertion propagates asynchronously through the synchronizer,
  // release is retimed by two flops so the rest of the block leaves reset
  // cleanly on a clock edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  assign rst_n_int = rst_sync_p1;

  assign session      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign session_rise = session && !session_q;
  assign session_fall = !session && session_q;

  // Address is in range when no bit at or above ADDR_WIDTH is set.
  assign in_range   = ((ioctl_addr >> ADDR_WIDTH) == 25'd0);
  assign rd_take    = (state == IDLE) && session && ioctl_rd;
  assign read_done  = (rd_take && !in_range) || ((state == DATA) && session);
  assign count_base = session_rise ? 16'd0 : byte_count;
  assign core_pause = session_q;

  // State register
  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; losing the session aborts any outstanding read.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rd_take && in_range) state_nxt = REQ;
      REQ: begin
        if (!session)       state_nxt = IDLE;
        else if (!mem_busy) state_nxt = DATA;
      end
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: request only when the port is free and the session holds.
  always_comb begin
    mem_rd = (state == REQ) && session && !mem_busy;
  end

  // Registered outputs
  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      session_q   <= 1'b0;
      upload_done <= 1'b0;
      ioctl_wait  <= 1'b0;
      ioctl_din   <= 8'h00;
      mem_addr    <= '0;
      byte_count  <= 16'd0;
    end else begin
      session_q   <= session;
      upload_done <= session_fall;
      // The HPS is stalled exactly while a read is outstanding.
      ioctl_wait  <= (state_nxt != IDLE);
      if (rd_take && in_range) begin
        mem_addr <= ioctl_addr[ADDR_WIDTH-1:0];
      end
      if (rd_take && !in_range) begin
        ioctl_din <= 8'hFF;
      end else if ((state == DATA) && session) begin
        ioctl_din <= mem_dout;
      end
      byte_count <= read_done ? sat_inc16(count_base) : count_base;
    end
  end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Bench for ioctl_upload_server: directed latency/boundary cases plus a
// randomized read session, checked by a scoreboard fed from a reference
// view of the backing memory.
module tb_ioctl_upload_server;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic        mem_busy = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic        core_pause;
  logic        upload_done;
  logic [15:0] byte_count;

  ioctl_upload_server #(.UPLOAD_INDEX(8'd2), .ADDR_WIDTH(12)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_busy(mem_busy), .mem_dout(mem_dout),
    .core_pause(core_pause), .upload_done(upload_done), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Backing memory: registered read, data valid the cycle after mem_rd.
  logic [7:0] mem [0:4095];
  always @(posedge clk_sys) if (mem_rd) mem_dout <= mem[mem_addr];

  int         n_vec = 0;
  int         n_mis = 0;
  logic [7:0] exp_q[$];
  bit         busy_rand = 1'b0;

  // Byte the HPS should see for an address: memory contents or 8'hFF.
  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    return (a < 25'd4096) ? mem[a[11:0]] : 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    if (busy_rand) mem_busy = ($urandom_range(0, 2) == 0);
  endtask

  task automatic sample(input string tag, input logic w, input logic r);
    @(negedge clk_sys);
    chk({tag, "_wait"}, 32'(ioctl_wait), 32'(w));
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'(r));
  endtask

  // One HPS read; the HPS holds off while ioctl_wait is high, occasionally
  // strobing ioctl_rd anyway (those strobes must be ignored).
  task automatic issue_read(input logic [24:0] a);
    int k;
    exp_q.push_back(ref_byte(a));
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    k = 0;
    while (ioctl_wait && k < 100) begin
      if ($urandom_range(0, 3) == 0) begin
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'($urandom);
      end else begin
        ioctl_rd = 1'b0;
      end
      step();
      k++;
    end
    ioctl_rd = 1'b0;
    if (k >= 100) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: every completed read shows up as a +1 on byte_count; pop the
  // expected byte and compare. ioctl_din must not change otherwise.
  initial begin
    logic [15:0] prev_cnt;
    logic [7:0]  prev_din;
    logic [7:0]  e;
    prev_cnt = 16'd0;
    prev_din = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        prev_cnt = 16'd0;
        prev_din = 8'h00;
      end else begin
        if ({1'b0, byte_count} == {1'b0, prev_cnt} + 17'd1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_read_done", 32'(byte_count), 32'(prev_cnt));
          end else begin
            e = exp_q.pop_front();
            chk("sb_din", 32'(ioctl_din), 32'(e));
          end
        end else if (ioctl_din !== prev_din) begin
          chk("din_changed_without_read", 32'(ioctl_din), 32'(prev_din));
        end
        if (mem_rd) chk("mem_rd_while_busy", 32'(mem_busy), 32'd0);
        prev_cnt = byte_count;
        prev_din = ioctl_din;
      end
    end
  end

  initial begin
    bit   b035 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic w035 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic r035 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic w034 [3] = '{1'b1, 1'b1, 1'b0};
    logic r034 [3] = '{1'b1, 1'b0, 1'b0};
    int   n_rand;
    logic [24:0] a;

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h010] = 8'hA5;

    // Reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_pause", 32'(core_pause), 32'd0);
    chk("rst_done", 32'(upload_done), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    step();
    reset_n = 1'b1;
    repeat (4) step();

    // Session 1 start: core_pause rises the cycle after
    ioctl_index  = 8'd2;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk("s1_pause_t0", 32'(core_pause), 32'd0);
    step();
    @(negedge clk_sys);
    chk("s1_pause_t1", 32'(core_pause), 32'd1);
    step();

    // Best-case read of 0x010
    exp_q.push_back(ref_byte(25'h010));
    ioctl_addr = 25'h010;
    ioctl_rd   = 1'b1;
    sample("r034_t0", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      ioctl_rd = 1'b0;
      sample($sformatf("r034_t%0d", i + 1), w034[i], r034[i]);
    end
    chk("r034_din", 32'(ioctl_din), 32'hA5);
    chk("r034_count", 32'(byte_count), 32'd1);

    // Read with mem_busy high for three cycles
    step();
    exp_q.push_back(ref_byte(25'h020));
    ioctl_addr = 25'h020;
    ioctl_rd   = 1'b1;
    sample("r035_t0", 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      ioctl_rd = 1'b0;
      mem_busy = b035[i];
      sample($sformatf("r035_t%0d", i + 1), w035[i], r035[i]);
    end
    chk("r035_din", 32'(ioctl_din), 32'(mem[12'h020]));
    chk("r035_count", 32'(byte_count), 32'd2);

    // Out-of-range address answers 8'hFF without stalling
    step();
    exp_q.push_back(ref_byte(25'h1000));
    ioctl_addr = 25'h1000;
    ioctl_rd   = 1'b1;
    sample("r036_t0", 1'b0, 1'b0);
    step();
    ioctl_rd = 1'b0;
    sample("r036_t1", 1'b0, 1'b0);
    chk("r036_din", 32'(ioctl_din), 32'hFF);
    chk("r036_count", 32'(byte_count), 32'd3);

    // Session drops while stuck in REQ: abort, no mem_rd, session-end pulse
    step();
    mem_busy   = 1'b1;
    ioctl_addr = 25'h030;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    sample("abort_t1", 1'b1, 1'b0);
    step();
    ioctl_upload = 1'b0;
    mem_busy     = 1'b0;
    sample("abort_t2", 1'b1, 1'b0);
    chk("abort_t2_done", 32'(upload_done), 32'd0);
    chk("abort_t2_pause", 32'(core_pause), 32'd1);
    step();
    sample("abort_t3", 1'b0, 1'b0);
    chk("abort_din", 32'(ioctl_din), 32'hFF);
    chk("abort_count", 32'(byte_count), 32'd3);
    chk("abort_done", 32'(upload_done), 32'd1);
    chk("abort_pause", 32'(core_pause), 32'd0);
    step();
    @(negedge clk_sys);
    chk("abort_done_single", 32'(upload_done), 32'd0);
    chk("abort_count_hold", 32'(byte_count), 32'd3);

    // Foreign index: no response at all
    step();
    ioctl_index  = 8'd3;
    ioctl_upload = 1'b1;
    ioctl_addr   = 25'h010;
    ioctl_rd     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample($sformatf("idx3_t%0d", i), 1'b0, 1'b0);
      chk("idx3_pause", 32'(core_pause), 32'd0);
      chk("idx3_din", 32'(ioctl_din), 32'hFF);
      chk("idx3_count", 32'(byte_count), 32'd3);
      step();
    end
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    repeat (2) step();

    // Session 2: count clears, read coinciding with session end is ignored
    ioctl_index  = 8'd2;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk("s2_count_t0", 32'(byte_count), 32'd3);
    step();
    @(negedge clk_sys);
    chk("s2_count_clear", 32'(byte_count), 32'd0);
    step();
    ioctl_upload = 1'b0;
    ioctl_addr   = 25'h010;
    ioctl_rd     = 1'b1;
    sample("endrd_t0", 1'b0, 1'b0);
    step();
    ioctl_rd = 1'b0;
    sample("endrd_t1", 1'b0, 1'b0);
    chk("endrd_count", 32'(byte_count), 32'd0);
    chk("endrd_din", 32'(ioctl_din), 32'hFF);
    chk("endrd_done", 32'(upload_done), 32'd1);
    repeat (2) step();

    // Session 3: full 4096-byte sequential upload
    ioctl_upload = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 4096; i++) issue_read(25'(i));
    step();
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("s3_done_t0", 32'(upload_done), 32'd0);
    chk("s3_pause_t0", 32'(core_pause), 32'd1);
    step();
    @(negedge clk_sys);
    chk("s3_done_t1", 32'(upload_done), 32'd1);
    chk("s3_pause_t1", 32'(core_pause), 32'd0);
    chk("s3_count", 32'(byte_count), 32'd4096);
    step();
    @(negedge clk_sys);
    chk("s3_done_t2", 32'(upload_done), 32'd0);
    chk("s3_count_hold", 32'(byte_count), 32'd4096);
    step();

    // Session 4: random addresses with random memory contention
    ioctl_upload = 1'b1;
    repeat (2) step();
    busy_rand = 1'b1;
    n_rand = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 7) == 0) a = 25'($urandom_range(4096, 33554431));
      else                           a = 25'($urandom_range(0, 4095));
      issue_read(a);
      n_rand++;
    end
    busy_rand = 1'b0;
    mem_busy  = 1'b0;
    step();
    @(negedge clk_sys);
    chk("s4_count", 32'(byte_count), 32'(n_rand));
    step();
    ioctl_upload = 1'b0;
    repeat (3) step();

    // Reset asserted while a read is being requested
    ioctl_upload = 1'b1;
    repeat (2) step();
    mem_busy   = 1'b1;
    ioctl_addr = 25'h005;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    step();
    mem_busy = 1'b0;
    #1;
    chk("mid_rd_mem_rd", 32'(mem_rd), 32'd1);
    chk("mid_rd_wait", 32'(ioctl_wait), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_mem_rd", 32'(mem_rd), 32'd0);
    chk("arst_wait", 32'(ioctl_wait), 32'd0);
    chk("arst_din", 32'(ioctl_din), 32'h00);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_pause", 32'(core_pause), 32'd0);
    chk("arst_done", 32'(upload_done), 32'd0);
    chk("arst_count", 32'(byte_count), 32'd0);
    ioctl_upload = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (5) step();

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ioctl_upload_server.md
IOCTL_UPLOAD_SERVER -- requirements
Module: ioctl_upload_server

Interface
REQ-001 SHALL have parameter UPLOAD_INDEX, default 8'd2, meaning the ioctl_index value served by this block.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning the width of the backing memory byte address.
REQ-003 SHALL have port clk_sys, input, 1, the single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ioctl_upload, input, 1, level: HPS upload session active.
REQ-006 SHALL have port ioctl_index, input, 8, file index of the current session.
REQ-007 SHALL have port ioctl_rd, input, 1, single-cycle byte-read strobe from HPS.
REQ-008 SHALL have port ioctl_addr, input, 25, byte address qualified by ioctl_rd.
REQ-009 SHALL have port ioctl_din, output, 8, byte returned to HPS.
REQ-010 SHALL have port ioctl_wait, output, 1, stall to HPS; high while a read is outstanding.
REQ-011 SHALL have port mem_addr, output, ADDR_WIDTH, read address to the shared memory port.
REQ-012 SHALL have port mem_rd, output, 1, read request to the shared memory port.
REQ-013 SHALL have port mem_busy, input, 1, core owns the memory port this cycle.
REQ-014 SHALL have port mem_dout, input, 8, memory data, valid the cycle after an accepted mem_rd.
REQ-015 SHALL have port core_pause, output, 1, freeze request to the core CPU.
REQ-016 SHALL have port upload_done, output, 1, one-cycle pulse at session end.
REQ-017 SHALL have port byte_count, output, 16, reads completed in the current or last session.

Function
REQ-018 SHALL define session = ioctl_upload && (ioctl_index == UPLOAD_INDEX); ioctl_rd outside a session is ignored (no wait, no mem_rd, ioctl_din unchanged).
REQ-019 SHALL implement states IDLE, REQ, DATA.
REQ-020 IDLE: on ioctl_rd in session with ioctl_addr < 2**ADDR_WIDTH, SHALL latch mem_addr <= ioctl_addr[ADDR_WIDTH-1:0], set ioctl_wait <= 1, go to REQ.
REQ-021 IDLE: on ioctl_rd in session with ioctl_addr >= 2**ADDR_WIDTH, SHALL set ioctl_din <= 8'hFF, increment byte_count, stay IDLE, never assert ioctl_wait or mem_rd.
REQ-022 REQ: mem_rd SHALL be combinational (state==REQ && !mem_busy); if accepted, go to DATA; else stay in REQ with ioctl_wait held high, indefinitely.
REQ-023 DATA: SHALL latch ioctl_din <= mem_dout, clear ioctl_wait, increment byte_count (saturating at 16'hFFFF), go to IDLE.
REQ-024 Best-case latency: ioctl_rd at cycle T gives ioctl_wait high in T+1 and T+2, mem_rd in T+1, ioctl_din valid and ioctl_wait low from T+3; each mem_busy cycle in REQ adds one cycle.
REQ-025 SHALL ignore ioctl_rd while in REQ or DATA; no queuing.
REQ-026 If the session ends while in REQ or DATA, SHALL abort to IDLE next cycle, clear ioctl_wait, leave ioctl_din and byte_count unchanged, and not issue mem_rd in that cycle.
REQ-027 core_pause SHALL rise the cycle after session start and fall one cycle after session end.
REQ-028 upload_done SHALL pulse one cycle, in the cycle after session falls.
REQ-029 byte_count SHALL clear to 0 in the cycle after session rises and hold its value after the session ends.
REQ-030 Session end and ioctl_rd in the same cycle: the read SHALL be ignored.

Reset
REQ-031 While reset_n is low, SHALL force state IDLE, ioctl_din 8'h00, ioctl_wait 0, mem_addr 0, mem_rd 0, core_pause 0, upload_done 0, byte_count 0.
REQ-032 Deassertion of reset_n SHALL be synchronized to clk_sys; the first transition is permitted on the second rising edge after release.
REQ-033 Reset asserted mid-read SHALL drop ioctl_wait and mem_rd immediately (asynchronously).

Verification
REQ-034 Index 2, session on, mem_busy=0, mem[0x010]=8'hA5, ioctl_rd addr 0x010 at T -> mem_rd at T+1, wait high T+1..T+2, ioctl_din=8'hA5 at T+3, byte_count=1.
REQ-035 Same as REQ-034 with mem_busy high T+1..T+3 -> mem_rd at T+4, ioctl_din valid at T+6, wait high T+1..T+5.
REQ-036 ioctl_rd addr 0x1000 (ADDR_WIDTH=12) -> ioctl_din=8'hFF next cycle, no wait, no mem_rd, byte_count increments.
REQ-037 ioctl_index=3 with ioctl_rd -> no response at all, core_pause stays 0.
REQ-038 4096 sequential reads, then ioctl_upload falls -> byte_count=4096, upload_done single pulse, core_pause low one cycle after the fall.
REQ-039 Drop ioctl_upload while in REQ (mem_busy=1) -> IDLE next cycle, wait low, no mem_rd; reset_n pulsed mid-read -> all outputs to their reset values.
